alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Arbitrates the single 32-bit integer ALU between two requesters: port 0 is the execute stage, port 1 is the branch/compare helper.
- Uses a valid/ready request and response handshake with one outstanding operation.
- Operands are latched on acceptance. The ALU result and flags are held until the owning requester takes them.
- Sits beside the execute stage and instantiates the existing alu block.

Parameters:
- PRIO_RR, 1, arbitration policy: 1 = round-robin between ports, 0 = fixed priority with port 0 winning.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accept; a request is accepted when valid and ready are both high in the same cycle.
- req_a  in  64  operand A, packed {port1, port0}.
- req_b  in  64  operand B, packed {port1, port0}.
- req_op  in  6  ALUControl code, packed {port1, port0}.
- rsp_valid  out  2  response valid; at most one bit is high, and it marks the owner.
- rsp_ready  in  2  per-port response accept.
- rsp_result  out  32  ALU result, qualified by rsp_valid.
- rsp_flags  out  4  {n, z, c, v} from the ALU, qualified by rsp_valid.
- rsp_err  out  1  response carries an undefined op code, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, state=IDLE, owner=0, last_grant=1 (so port 0 wins the first tie).
- Reset mid-operation: an in-flight response is dropped; nothing is ever delivered for it.
- State machine has two states:
  - IDLE: no operation is held.
  - RESP: an operation is latched and its response is being presented.
- Arbitration (combinational; a grant exists only in IDLE, or in RESP in the cycle the response fires):
  - Only one requester valid: grant it.
  - Both valid, PRIO_RR=1: grant the port that is not last_grant.
  - Both valid, PRIO_RR=0: grant port 0.
  - req_ready[g]=1 only for the granted port g; the other bit is 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On acceptance:
  - Latch a, b, op and owner.
  - last_grant updates only on acceptance.
  - Next state is RESP.
  - Requester inputs may change freely afterwards.
- In RESP:
  - rsp_valid[owner]=1.
  - rsp_result and rsp_flags come from the alu instance driven by the latched operands.
  - All response outputs stay stable while rsp_ready[owner]=0.
  - rsp_ready of the non-owner is ignored.
- Response fire (rsp_valid[owner] & rsp_ready[owner]):
  - If a new request is accepted in the same cycle, stay in RESP with new latches. This gives back-to-back throughput of 1 op/cycle.
  - Otherwise go to IDLE.
- Latency: response valid in the cycle after acceptance.
- Undefined op codes (100, 110, 111):
  - Result is 0, as the ALU produces.
  - Flags are forwarded unmodified from the ALU.
  - rsp_err=1.
- Arithmetic is exactly the alu semantics:
  - op 000 add, 001 sub, 010 and, 011 or, 101 slt (sign of the difference).
  - c and v are meaningful for add/sub only.
- Starvation bound (PRIO_RR=1): a continuously valid port waits at most one foreign operation.
- Width rules: 32-bit operands, no sign or zero extension inside the block.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - State encoding: IDLE=1'b0, RESP=1'b1.
  - Flag bit positions: N=3, Z=2, C=1, V=0.
- One sub-module: the existing alu, instantiated once.
- Arbitration and the FSM stay inline.

Test Plan:
- Port 0 add, a=5, b=7, op=000 -> next cycle rsp_valid=01, result=12, flags=0000, rsp_err=0.
- After reset, both ports valid in the same cycle; port0 sub 3-3, port1 slt a=0xFFFFFFFF, b=1:
  - Cycle 1: port 0 is granted.
  - Cycle 2 response: result 0, z=1, c=1, with port 1 accepted in the same cycle.
  - Cycle 3: rsp_valid=10, result 1.
- Hold rsp_ready[owner]=0 for 3 cycles with port 1 valid -> result and flags stable, req_ready=00. Raise rsp_ready -> port 1 is accepted that cycle, and its response follows the next cycle.
- Overflow: 0x7FFFFFFF + 1, op 000 -> result 0x80000000, n=1, v=1, z=0, c=0. Op 110 -> result 0, rsp_err=1.
- PRIO_RR=0 with both ports valid continuously and rsp_ready=11 -> port 0 granted every cycle and port 1 never granted. Same stimulus with PRIO_RR=1 -> grants alternate 0, 1, 0, 1.
- Assert rst in the cycle rsp_valid=01 with rsp_ready=0 -> next cycle all outputs are at reset values, and the dropped response never appears.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared constants and types for the two-port ALU arbiter and its ALU.
package alu_share_arb_pkg;

   localparam int unsigned DW  = 32;
   localparam int unsigned OPW = 3;
   localparam int unsigned FW  = 4;

   localparam logic [OPW-1:0] ALU_ADD = 3'b000;
   localparam logic [OPW-1:0] ALU_SUB = 3'b001;
   localparam logic [OPW-1:0] ALU_AND = 3'b010;
   localparam logic [OPW-1:0] ALU_OR  = 3'b011;
   localparam logic [OPW-1:0] ALU_SLT = 3'b101;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef struct packed {
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [OPW-1:0] op;
   } alu_req_t;

   function automatic logic op_defined(input logic [OPW-1:0] op);
      logic ok;
      case (op)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: ok = 1'b1;
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Existing 32-bit integer ALU: purely combinational result and {n,z,c,v} flags.
module alu_share_arb_alu
   import alu_share_arb_pkg::*;
(
   input  logic [DW-1:0]  a_i,
   input  logic [DW-1:0]  b_i,
   input  logic [OPW-1:0] op_i,
   output logic [DW-1:0]  result_c,
   output logic [FW-1:0]  flags_c
);

   logic [DW:0] sum;
   logic [DW:0] diff;
   logic        carry;
   logic        ovf;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} + {1'b0, ~b_i} + (DW+1)'(1);

   // Carry on subtract is the no-borrow bit of a + ~b + 1.
   always_comb begin
      result_c = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      case (op_i)
         ALU_ADD: begin
            result_c = sum[DW-1:0];
            carry    = sum[DW];
            ovf      = (a_i[DW-1] == b_i[DW-1]) && (sum[DW-1] != a_i[DW-1]);
         end
         ALU_SUB: begin
            result_c = diff[DW-1:0];
            carry    = diff[DW];
            ovf      = (a_i[DW-1] != b_i[DW-1]) && (diff[DW-1] != a_i[DW-1]);
         end
         ALU_AND: result_c = a_i & b_i;
         ALU_OR:  result_c = a_i | b_i;
         ALU_SLT: result_c = DW'(diff[DW-1]);
         default: result_c = '0;
      endcase
      flags_c         = '0;
      flags_c[FLAG_N] = result_c[DW-1];
      flags_c[FLAG_Z] = (result_c == '0);
      flags_c[FLAG_C] = carry;
      flags_c[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the execute stage (port 0) and the branch helper (port 1);
// one operation in flight, response held until its owner takes it.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter bit PRIO_RR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*DW-1:0]   req_a,
   input  logic [2*DW-1:0]   req_b,
   input  logic [2*OPW-1:0]  req_op,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DW-1:0]     rsp_result,
   output logic [FW-1:0]     rsp_flags,
   output logic              rsp_err
);

   logic [0:0] state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_grant_q, last_grant_d;
   alu_req_t   lat_q, lat_d;

   logic          fire;
   logic          grant_en;
   logic          grant_port;
   logic          grant_vld;
   logic [DW-1:0] alu_result;
   logic [FW-1:0] alu_flags;

   alu_share_arb_alu u_alu (
      .a_i      (lat_q.a),
      .b_i      (lat_q.b),
      .op_i     (lat_q.op),
      .result_c (alu_result),
      .flags_c  (alu_flags)
   );

   // No acceptance while reset is high: the request would be dropped by the reset.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      lat_d        = lat_q;
      grant_port   = 1'b0;

      fire      = (state_q == RESP) && rsp_ready[owner_q];
      grant_en  = !rst && ((state_q == IDLE) || fire);
      grant_vld = grant_en && (req_valid != 2'b00);

      case (req_valid)
         2'b10:   grant_port = 1'b1;
         2'b11:   grant_port = PRIO_RR ? !last_grant_q : 1'b0;
         default: grant_port = 1'b0;
      endcase

      req_ready = 2'b00;
      if (grant_vld) begin
         req_ready    = grant_port ? 2'b10 : 2'b01;
         state_d      = RESP;
         owner_d      = grant_port;
         last_grant_d = grant_port;
         lat_d.a      = grant_port ? req_a[2*DW-1:DW]   : req_a[DW-1:0];
         lat_d.b      = grant_port ? req_b[2*DW-1:DW]   : req_b[DW-1:0];
         lat_d.op     = grant_port ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
      end else if (fire) begin
         state_d = IDLE;
      end

      rsp_valid  = 2'b00;
      rsp_result = '0;
      rsp_flags  = '0;
      rsp_err    = 1'b0;
      if (state_q == RESP) begin
         rsp_valid  = owner_q ? 2'b10 : 2'b01;
         rsp_result = alu_result;
         rsp_flags  = alu_flags;
         rsp_err    = !op_defined(lat_q.op);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         lat_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         lat_q        <= lat_d;
      end
   end

endmodule
